imm_ext_unit: RTL
=================

IMM_EXT_UNIT -- requirements
Module: imm_ext_unit

Interface
REQ-001 Parameter IN_W, default 7, raw immediate width.
REQ-002 Parameter OUT_W, default 16, extended output width.
REQ-003 Parameter PFX_TMO, default 4, idle cycles before a held prefix expires.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  immediate request present.
REQ-007 in_imm  input  IN_W  raw immediate field.
REQ-008 in_mode  input  2  00 sign-ext, 01 zero-ext, 10 sign-ext then shift left 1, 11 prefix load.
REQ-009 in_ready  output  1  unit accepts a request this cycle.
REQ-010 out_valid  output  1  out_imm holds a result.
REQ-011 out_imm  output  OUT_W  extended immediate.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 pfx_drop  output  1  one-cycle pulse: held prefix expired unused.

Function
REQ-014 The unit SHALL accept a request when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-015 Mode 00 SHALL replicate in_imm[IN_W-1] into bits OUT_W-1:IN_W.
REQ-016 Mode 01 SHALL fill bits OUT_W-1:IN_W with zero.
REQ-017 Mode 10 SHALL sign-extend, then shift left 1 (bit 0 = 0, MSB discarded).
REQ-018 Mode 11 SHALL store in_imm in the prefix register, go IDLE->PFX, and produce no output.
REQ-019 In PFX, an accepted mode 00/01/10 request SHALL use {prefix, in_imm} (2*IN_W bits) as its operand instead of in_imm, then apply that mode, then return to IDLE.
REQ-020 In PFX, an accepted mode 11 request SHALL overwrite the prefix, remain in PFX, and restart the timeout.
REQ-021 The timeout counter SHALL count cycles in PFX with no accepted request; on reaching PFX_TMO it SHALL pulse pfx_drop for one cycle and return to IDLE.
REQ-022 A request accepted in the same cycle the counter reaches PFX_TMO SHALL win: it consumes the prefix, and no pfx_drop is issued.
REQ-023 Latency SHALL be one cycle: a result accepted at edge N is on out_imm with out_valid=1 after edge N.
REQ-024 While out_valid && !out_ready, out_imm SHALL hold stable and in_ready SHALL be 0.
REQ-025 When out_ready=1 and a new request is accepted in the same cycle, out_valid SHALL stay 1 and out_imm SHALL update (no bubble).
REQ-026 Elaboration SHALL fail if IN_W >= OUT_W or 2*IN_W > OUT_W.

Reset
REQ-027 On rst: out_valid=0, out_imm=0, pfx_drop=0, state IDLE, prefix register=0, timeout counter=0.
REQ-028 Reset asserted while in PFX SHALL discard the prefix without pulsing pfx_drop.

Configuration
REQ-029 Macro IMM_EXT_PREFIX_EN defined: prefix mode, PFX state, timeout counter and pfx_drop are present as specified.
REQ-030 Macro IMM_EXT_PREFIX_EN undefined: mode 11 SHALL behave as mode 00, no PFX state exists, and pfx_drop SHALL be tied to 0.

Structure
REQ-031 Package imm_ext_pkg SHALL hold the mode enum (MODE_SEXT, MODE_ZEXT, MODE_SHL1, MODE_PFX) and the state enum (ST_IDLE, ST_PFX).
REQ-032 The combinational extend/shift datapath SHALL be a sub-module imm_ext_fn, parameterised by operand width and OUT_W, instantiated once.

Verification (IN_W=7, OUT_W=16, PFX_TMO=4, out_ready=1 unless stated)
REQ-033 Mode 00, imm 7'h32 -> out_imm 16'h0032; mode 00, imm 7'h7A -> 16'hFFFA, each one cycle after acceptance.
REQ-034 Mode 01, imm 7'h7A -> 16'h007A; mode 10, imm 7'h7A -> 16'hFFF4.
REQ-035 Mode 11 imm 7'h05, then mode 00 imm 7'h12 -> single output 16'h0292, no output for the prefix, state back to IDLE.
REQ-036 Mode 11 imm 7'h05, then 4 idle cycles -> pfx_drop pulses once; then mode 00 imm 7'h12 -> 16'h0012.
REQ-037 out_ready=0 for 3 cycles after result 16'hFFFA -> in_ready=0, out_imm held at 16'hFFFA; back-to-back requests with out_ready=1 -> one result per cycle.
REQ-038 rst pulsed while in PFX -> outputs zero, no pfx_drop; next mode 00 imm 7'h12 -> 16'h0012.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate extension unit: request modes and the
// prefix-tracking state.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SEXT = 2'b00,
    MODE_ZEXT = 2'b01,
    MODE_SHL1 = 2'b10,
    MODE_PFX  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PFX  = 1'b1
  } state_e;

endpackage

// File: rtl/imm_ext_fn.sv
// Combinational extend/shift datapath: widens an OP_W-bit operand to OUT_W
// bits by sign or zero extension, optionally shifting left by one.
module imm_ext_fn
  import imm_ext_pkg::*;
#(
  parameter int OP_W  = 14,
  parameter int OUT_W = 16
) (
  input  logic [OP_W-1:0]  i_operand,
  input  logic [1:0]       i_mode,
  output logic [OUT_W-1:0] o_result
);

  logic [OUT_W-1:0] w_ext;

  // Extend to full width, then apply the optional shift (MSB falls off).
  always_comb begin
    if (i_mode == MODE_ZEXT) begin
      w_ext = OUT_W'(i_operand);
    end else begin
      w_ext = OUT_W'($signed(i_operand));
    end
    if (i_mode == MODE_SHL1) begin
      o_result = {w_ext[OUT_W-2:0], 1'b0};
    end else begin
      o_result = w_ext;
    end
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Immediate extension unit with a one-deep output register and a
// ready/valid handshake on both sides.
// Optional feature macro IMM_EXT_PREFIX_EN: when defined, mode 11 loads a
// prefix that is concatenated above the next immediate; an unused prefix
// expires after PFX_TMO idle cycles with a pfx_drop pulse. When undefined,
// mode 11 behaves as sign extension and pfx_drop is tied low.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W    = 7,
  parameter int OUT_W   = 16,
  parameter int PFX_TMO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_imm,
  input  logic             out_ready,
  output logic             pfx_drop
);

  localparam int OP_W = 2 * IN_W;

  generate
    if (IN_W >= OUT_W || OP_W > OUT_W || PFX_TMO < 1) begin : g_bad_param
      $error("imm_ext_unit: need 2*IN_W <= OUT_W, IN_W < OUT_W, PFX_TMO >= 1");
    end
  endgenerate

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_imm;
  logic             w_accept;
  mode_e            w_mode;
  mode_e            w_eff_mode;
  logic             w_pfx_load;
  logic             w_in_pfx;
  logic [IN_W-1:0]  w_prefix;
  logic [OP_W-1:0]  w_operand;
  logic [OUT_W-1:0] w_result;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_mode    = mode_e'(in_mode);
  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;

`ifdef IMM_EXT_PREFIX_EN
  localparam int CNT_W = $clog2(PFX_TMO + 1);

  state_e           r_state;
  logic [IN_W-1:0]  r_prefix;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pfx_drop;

  assign w_eff_mode = w_mode;
  assign w_pfx_load = (w_mode == MODE_PFX);
  assign w_in_pfx   = (r_state == ST_PFX);
  assign w_prefix   = r_prefix;
  assign pfx_drop   = r_pfx_drop;

  // Prefix FSM: load on mode 11, consume on any other accepted request,
  // expire after PFX_TMO cycles in PFX without an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_prefix   <= '0;
      r_cnt      <= '0;
      r_pfx_drop <= 1'b0;
    end else begin
      r_pfx_drop <= 1'b0;
      if (w_accept && w_pfx_load) begin
        r_prefix <= in_imm;
        r_state  <= ST_PFX;
        r_cnt    <= '0;
      end else if (w_accept) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (r_state == ST_PFX) begin
        if (r_cnt == CNT_W'(PFX_TMO - 1)) begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_pfx_drop <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end
`else
  assign w_eff_mode = (w_mode == MODE_PFX) ? MODE_SEXT : w_mode;
  assign w_pfx_load = 1'b0;
  assign w_in_pfx   = 1'b0;
  assign w_prefix   = '0;
  assign pfx_drop   = 1'b0;
`endif

  // Operand: prefix concatenation when one is held, otherwise the raw
  // immediate pre-extended so the datapath sees a uniform width.
  always_comb begin
    if (w_in_pfx) begin
      w_operand = {w_prefix, in_imm};
    end else if (w_eff_mode == MODE_ZEXT) begin
      w_operand = OP_W'(in_imm);
    end else begin
      w_operand = OP_W'($signed(in_imm));
    end
  end

  imm_ext_fn #(
    .OP_W  (OP_W),
    .OUT_W (OUT_W)
  ) u_fn (
    .i_operand (w_operand),
    .i_mode    (w_eff_mode),
    .o_result  (w_result)
  );

  // Output register: load on accepted non-prefix request, drain on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
    end else if (w_accept && !w_pfx_load) begin
      r_out_valid <= 1'b1;
      r_out_imm   <= w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
